// File: rtl/text_cursor_writer_pkg.sv
// Shared definitions for the text terminal engine: FSM encoding, control codes
// and the printable-range test used when decoding incoming bytes.
package text_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_LINE = 2'd1,
    CLEAR_ALL  = 2'd2
  } state_e;

  // Plain-vector copies of the enum so legacy code can hold state in logic [1:0]
  localparam logic [1:0] ST_IDLE       = IDLE;
  localparam logic [1:0] ST_CLEAR_LINE = CLEAR_LINE;
  localparam logic [1:0] ST_CLEAR_ALL  = CLEAR_ALL;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor_writer_if.sv
// Byte-stream input and character-RAM write port of the terminal engine.
// The engine uses the master view; the FIFO/RAM side uses the slave view.
interface text_cursor_writer_if #(
  parameter int ADDR_W = 12
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_cursor_writer_row_addr_gen.sv
// Maps a logical row (relative to the scrolled top row) to a physical row and
// linear character-RAM address; also used by the VGA scanout.
module row_addr_gen #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(COLS*ROWS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic [ROW_W-1:0]  top_row,
  input  logic [ROW_W-1:0]  cur_row,
  input  logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  phys_row,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ROW_W:0] ROWS_X = (ROW_W+1)'(ROWS);

  logic [ROW_W:0] sum;

  // Both operands are < ROWS, so a single conditional subtract is a full modulo
  always_comb begin
    sum      = {1'b0, top_row} + {1'b0, cur_row};
    phys_row = (sum >= ROWS_X) ? ROW_W'(sum - ROWS_X) : sum[ROW_W-1:0];
    addr     = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col);
  end

endmodule

// File: rtl/text_cursor_writer.sv
// Terminal engine: consumes bytes from the UART FIFO, places glyphs at a cursor
// in the VGA character RAM, and scrolls via a circular top-row offset.
module text_cursor_writer
  import text_pkg::*;
#(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter bit         AUTO_CR      = 1'b1,
  parameter bit         CLEAR_ON_RST = 1'b1,
  parameter logic [7:0] BLANK        = 8'h20,
  parameter int         ADDR_W       = $clog2(COLS*ROWS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  text_cursor_writer_if.master      bus,
  output logic [$clog2(ROWS)-1:0]   top_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic                      busy
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS-1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS-1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] LINE_SPAN = ADDR_W'(COLS-1);

  logic [1:0]        state_q,    state_d;
  logic [ROW_W-1:0]  top_q,      top_d;
  logic [ROW_W-1:0]  row_q,      row_d;
  logic [COL_W-1:0]  col_q,      col_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] clr_last_q, clr_last_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [7:0]        wr_data_q,  wr_data_d;
  logic              busy_q,     busy_d;

  logic              accept;
  logic              newline;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] top_base;
  logic [ROW_W-1:0]  unused_cur_phys;
  logic [ROW_W-1:0]  unused_top_phys;

  // Cursor cell address
  row_addr_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cur_addr (
    .top_row  (top_q),
    .cur_row  (row_q),
    .col      (col_q),
    .phys_row (unused_cur_phys),
    .addr     (cur_addr)
  );

  // Start of the current top physical row: the line that a scroll exposes at the bottom
  row_addr_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_top_addr (
    .top_row  (top_q),
    .cur_row  ('0),
    .col      ('0),
    .phys_row (unused_top_phys),
    .addr     (top_base)
  );

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    row_d      = row_q;
    col_d      = col_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = 1'b0;
    newline    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(bus.in_data)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = bus.in_data;
            if (col_q != COL_LAST) begin
              col_d = col_q + 1'b1;
            end else begin
              col_d   = '0;
              newline = 1'b1;
            end
          end else begin
            case (bus.in_data)
              CC_CR: col_d = '0;
              CC_LF: begin
                newline = 1'b1;
                if (AUTO_CR) col_d = '0;
              end
              CC_BS: begin
                // At column 0 backspace is a no-op: it never backs up a row
                if (col_q != '0) begin
                  col_d     = col_q - 1'b1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_addr - 1'b1;
                  wr_data_d = BLANK;
                end
              end
              CC_FF: begin
                state_d    = ST_CLEAR_ALL;
                clr_addr_d = '0;
                clr_last_d = CELL_LAST;
              end
              default: ;
            endcase
          end

          // A wrapping glyph write and the scroll it triggers share one decision,
          // so the line clear follows the glyph write with no idle cycle.
          if (newline) begin
            if (row_q != ROW_LAST) begin
              row_d = row_q + 1'b1;
            end else begin
              top_d      = (top_q == ROW_LAST) ? '0 : top_q + 1'b1;
              state_d    = ST_CLEAR_LINE;
              clr_addr_d = top_base;
              clr_last_d = top_base + LINE_SPAN;
            end
          end
        end
      end

      ST_CLEAR_LINE, ST_CLEAR_ALL: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = BLANK;
        busy_d     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == clr_last_q) begin
          state_d = ST_IDLE;
          if (state_q == ST_CLEAR_ALL) begin
            top_d = '0;
            row_d = '0;
            col_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Any pending write (glyph or clear) holds off the next byte for a cycle
    in_ready_d = (state_d == ST_IDLE) && !wr_en_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ON_RST ? ST_CLEAR_ALL : ST_IDLE;
      top_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      clr_addr_q <= '0;
      clr_last_q <= CELL_LAST;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      row_q      <= row_d;
      col_q      <= col_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign top_row      = top_q;
  assign cur_col      = col_q;
  assign cur_row      = row_q;
  assign busy         = busy_q;

endmodule
